// File: rtl/simon_sound_pkg.sv
// Shared types and default timing constants for the Simon speaker driver.
// A jingle is four notes; the note index selects the oscillator tone.
package simon_sound_pkg;

   typedef enum logic [1:0] {IDLE, TONE, JNOTE, JGAP} state_t;
   typedef enum logic {J_LOSE, J_HS} jingle_t;
   typedef logic [1:0] note_t;

   localparam int DEF_DIV_W    = 16;
   localparam int DEF_LEN_W    = 20;
   localparam int DEF_HALF0    = 4000;
   localparam int DEF_HALF1    = 5000;
   localparam int DEF_HALF2    = 6000;
   localparam int DEF_HALF3    = 8000;
   localparam int DEF_NOTE_LEN = 400000;
   localparam int DEF_GAP_LEN  = 80000;

   // LOSE walks tones 0..3 (falling pitch); HS walks 3..0 (rising pitch).
   function automatic note_t jingle_tone(jingle_t j, note_t n);
      return (j == J_LOSE) ? n : ~n;
   endfunction

endpackage

// File: rtl/simon_sound_if.sv
// Controller-to-speaker-driver signal bundle.
interface simon_sound_if;
   logic [1:0] LAMP;
   logic       LAMP_ENA;
   logic       LOSE;
   logic       HS;
   logic       MUTE;
   logic       SPK;
   logic       BUSY;

   modport master (output LAMP, LAMP_ENA, LOSE, HS, MUTE, input SPK, BUSY);
   modport slave  (input LAMP, LAMP_ENA, LOSE, HS, MUTE, output SPK, BUSY);
endinterface

// File: rtl/simon_sound_tone_osc.sv
// Square-wave oscillator: SQ toggles every HALF enabled cycles.
// EN low parks the oscillator (count 0, SQ 0); CLR restarts the count but keeps SQ.
module tone_osc #(
   parameter int DIV_W = 16
)(
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLR,
   input  logic             EN,
   input  logic [DIV_W-1:0] HALF,
   output logic             SQ
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] last;

   assign last = HALF - DIV_W'(1);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= '0;
         SQ  <= 1'b0;
      end else if (!EN) begin
         cnt <= '0;
         SQ  <= 1'b0;
      end else if (CLR) begin
         cnt <= '0;
      end else if (cnt == last) begin
         cnt <= '0;
         SQ  <= ~SQ;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/simon_sound.sv
// Speaker driver: lamp tone while a lamp is lit, four-note jingles on LOSE / HS rising edges.
// MUTE only gates the pin; sequencing and BUSY run unchanged.
module simon_sound import simon_sound_pkg::*; #(
   parameter int DIV_W    = DEF_DIV_W,
   parameter int LEN_W    = DEF_LEN_W,
   parameter int HALF0    = DEF_HALF0,
   parameter int HALF1    = DEF_HALF1,
   parameter int HALF2    = DEF_HALF2,
   parameter int HALF3    = DEF_HALF3,
   parameter int NOTE_LEN = DEF_NOTE_LEN,
   parameter int GAP_LEN  = DEF_GAP_LEN
)(
   input logic          CLK,
   input logic          RST,
   simon_sound_if.slave bus
);

   localparam logic [LEN_W-1:0] NOTE_LAST = LEN_W'(NOTE_LEN - 1);
   localparam logic [LEN_W-1:0] GAP_LAST  = LEN_W'(GAP_LEN - 1);

   state_t           state, nxt;
   jingle_t          jingle, jingle_nxt;
   note_t            note, note_nxt;
   note_t            tone, tone_nxt;
   logic [LEN_W-1:0] len_cnt, len_nxt;
   logic             lose_prev, hs_prev, busy;
   logic             lose_rise, hs_rise;
   logic             osc_en, osc_clr, sq;
   logic [DIV_W-1:0] half_sel;

   assign lose_rise = bus.LOSE & ~lose_prev;
   assign hs_rise   = bus.HS & ~hs_prev;

   always_comb begin
      half_sel = DIV_W'(HALF3);
      case (tone)
         2'd0:    half_sel = DIV_W'(HALF0);
         2'd1:    half_sel = DIV_W'(HALF1);
         2'd2:    half_sel = DIV_W'(HALF2);
         default: half_sel = DIV_W'(HALF3);
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         jingle    <= J_LOSE;
         note      <= '0;
         tone      <= '0;
         len_cnt   <= '0;
         lose_prev <= 1'b0;
         hs_prev   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= nxt;
         jingle    <= jingle_nxt;
         note      <= note_nxt;
         tone      <= tone_nxt;
         len_cnt   <= len_nxt;
         lose_prev <= bus.LOSE;
         hs_prev   <= bus.HS;
         busy      <= (nxt == JNOTE) || (nxt == JGAP);
      end
   end

   // Any state change into TONE/JNOTE leaves osc_en low for that edge,
   // which hands the oscillator a fresh phase.
   always_comb begin
      nxt        = state;
      jingle_nxt = jingle;
      note_nxt   = note;
      tone_nxt   = tone;
      len_nxt    = '0;
      osc_en     = 1'b0;
      osc_clr    = 1'b0;
      if (lose_rise || (hs_rise && (state == IDLE || state == TONE))) begin
         nxt        = JNOTE;
         jingle_nxt = lose_rise ? J_LOSE : J_HS;
         note_nxt   = '0;
         tone_nxt   = jingle_tone(jingle_nxt, '0);
      end else begin
         case (state)
            IDLE, TONE: begin
               if (bus.LAMP_ENA) begin
                  nxt      = TONE;
                  tone_nxt = bus.LAMP;
                  if (state == TONE) begin
                     osc_en  = 1'b1;
                     osc_clr = (bus.LAMP != tone);
                  end
               end else begin
                  nxt = IDLE;
               end
            end
            JNOTE: begin
               if (len_cnt == NOTE_LAST) begin
                  nxt = (note == 2'd3) ? IDLE : JGAP;
               end else begin
                  len_nxt = len_cnt + LEN_W'(1);
                  osc_en  = 1'b1;
               end
            end
            JGAP: begin
               if (len_cnt == GAP_LAST) begin
                  nxt      = JNOTE;
                  note_nxt = note + 2'd1;
                  tone_nxt = jingle_tone(jingle, note_nxt);
               end else begin
                  len_nxt = len_cnt + LEN_W'(1);
               end
            end
            default: nxt = IDLE;
         endcase
      end
   end

   tone_osc #(.DIV_W(DIV_W)) u_osc (
      .CLK  (CLK),
      .RST  (RST),
      .CLR  (osc_clr),
      .EN   (osc_en),
      .HALF (half_sel),
      .SQ   (sq)
   );

   assign bus.SPK  = sq & ~bus.MUTE;
   assign bus.BUSY = busy;

endmodule
